serial_pattern_detector: RTL and testbench

SERIAL_PATTERN_DETECTOR -- requirements
Module: serial_pattern_detector

---
 rtl/serial_pattern_detector.sv | 89 ++++++++
 tb/tb_serial_pattern_detector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_detector.sv
// Serial detector for the bit pattern 1011 (first bit received first), with a saturating match counter.
// Define OVERLAP_DETECT_EN so that the trailing '1' of a match seeds the next pattern.
module serial_pattern_detector #(
   parameter int COUNT_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               din_valid,
   input  logic               din,
   input  logic               count_clr,
   output logic               detect,
   output logic [COUNT_W-1:0] match_count,
   output logic [1:0]         state_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      S1   = 2'd1,
      S10  = 2'd2,
      S101 = 2'd3
   } state_t;

   localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
   localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

`ifdef OVERLAP_DETECT_EN
   localparam state_t MATCH_NEXT = S1;
`else
   localparam state_t MATCH_NEXT = IDLE;
`endif

   state_t             state_q, state_d;
   logic               detect_q, detect_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               match_s;

   // Next-state, match pulse and counter update
   always_comb begin
      state_d  = state_q;
      match_s  = 1'b0;
      detect_d = 1'b0;
      count_d  = count_q;
      if (din_valid) begin
         case (state_q)
            IDLE:    state_d = din ? S1 : IDLE;
            S1:      state_d = din ? S1 : S10;
            S10:     state_d = din ? S101 : IDLE;
            S101: begin
               if (din) begin
                  match_s = 1'b1;
                  state_d = MATCH_NEXT;
               end else begin
                  state_d = S10;
               end
            end
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
      detect_d = match_s;
      // Clear wins over a simultaneous increment; the count never wraps
      if (count_clr) begin
         count_d = {COUNT_W{1'b0}};
      end else if (match_s && (count_q != COUNT_MAX)) begin
         count_d = count_q + COUNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // State, detect and counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         detect_q <= 1'b0;
         count_q  <= {COUNT_W{1'b0}};
      end else begin
         state_q  <= state_d;
         detect_q <= detect_d;
         count_q  <= count_d;
      end
   end

   assign detect      = detect_q;
   assign match_count = count_q;
   assign state_out   = state_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector; a second instance with COUNT_W=2 shares the stimulus.
module tb_serial_pattern_detector;

   logic       clock;
   logic       reset;
   logic       din_valid;
   logic       din;
   logic       count_clr;
   logic       detect;
   logic [7:0] match_count;
   logic [1:0] state_out;
   logic       detect_s;
   logic [1:0] match_count_s;
   logic [1:0] state_out_s;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef OVERLAP_DETECT_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   serial_pattern_detector #(.COUNT_W(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .din_valid   (din_valid),
      .din         (din),
      .count_clr   (count_clr),
      .detect      (detect),
      .match_count (match_count),
      .state_out   (state_out)
   );

   serial_pattern_detector #(.COUNT_W(2)) dut_sat (
      .clock       (clock),
      .reset       (reset),
      .din_valid   (din_valid),
      .din         (din),
      .count_clr   (count_clr),
      .detect      (detect_s),
      .match_count (match_count_s),
      .state_out   (state_out_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic d, input logic c);
      @(negedge clock);
      din_valid = v;
      din       = d;
      count_clr = c;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clock);
      reset     = 1'b1;
      din_valid = 1'b1;
      din       = 1'b1;
      count_clr = 1'b0;
      repeat (cycles) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      din_valid = 1'b0;
      din       = 1'b0;
      count_clr = 1'b0;

      // Reset held 2 cycles with valid 1s on the input
      do_reset(2);
      chk("rst_detect", 16'(detect), 16'd0);
      chk("rst_count", 16'(match_count), 16'd0);
      chk("rst_state", 16'(state_out), 16'd0);
      chk("rst_count_sat", 16'(match_count_s), 16'd0);

      // Single match 1011
      step(1'b1, 1'b1, 1'b0); chk("single_s1", 16'(state_out), 16'd1);
      step(1'b1, 1'b0, 1'b0); chk("single_s10", 16'(state_out), 16'd2);
      step(1'b1, 1'b1, 1'b0); chk("single_s101", 16'(state_out), 16'd3);
      chk("single_nodet", 16'(detect), 16'd0);
      step(1'b1, 1'b1, 1'b0);
      chk("single_detect", 16'(detect), 16'd1);
      chk("single_count", 16'(match_count), 16'd1);
      chk("single_after_state", 16'(state_out), OVL ? 16'd1 : 16'd0);
      step(1'b0, 1'b1, 1'b0);
      chk("single_pulse_end", 16'(detect), 16'd0);
      chk("single_count_hold", 16'(match_count), 16'd1);

      // Overlap stream 1011011
      do_reset(1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0); chk("ovl_first_det", 16'(detect), 16'd1);
      step(1'b1, 1'b0, 1'b0); chk("ovl_b5_state", 16'(state_out), OVL ? 16'd2 : 16'd0);
      chk("ovl_b5_det", 16'(detect), 16'd0);
      step(1'b1, 1'b1, 1'b0); chk("ovl_b6_state", 16'(state_out), OVL ? 16'd3 : 16'd1);
      step(1'b1, 1'b1, 1'b0);
      chk("ovl_second_det", 16'(detect), OVL ? 16'd1 : 16'd0);
      chk("ovl_count", 16'(match_count), OVL ? 16'd2 : 16'd1);

      // Valid gaps with din=0, count_clr on the detecting edge
      do_reset(1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0); chk("gap_hold_s1", 16'(state_out), 16'd1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0); chk("gap_hold_s10", 16'(state_out), 16'd2);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0); chk("gap_hold_s101", 16'(state_out), 16'd3);
      chk("gap_nodet", 16'(detect), 16'd0);
      step(1'b1, 1'b1, 1'b1);
      chk("gap_detect", 16'(detect), 16'd1);
      chk("gap_clr_priority", 16'(match_count), 16'd0);
      chk("gap_clr_fsm", 16'(state_out), OVL ? 16'd1 : 16'd0);
      step(1'b0, 1'b0, 1'b0);
      chk("gap_pulse_end", 16'(detect), 16'd0);

      // Five separated matches: 2-bit counter saturates at 3
      do_reset(1);
      for (int p = 0; p < 5; p++) begin
         step(1'b1, 1'b1, 1'b0);
         step(1'b1, 1'b0, 1'b0);
         step(1'b1, 1'b1, 1'b0);
         step(1'b1, 1'b1, 1'b0);
         chk($sformatf("sat_detect_%0d", p), 16'(detect_s), 16'd1);
         chk($sformatf("sat_count_%0d", p), 16'(match_count_s), (p < 3) ? 16'(p + 1) : 16'd3);
         step(1'b0, 1'b0, 1'b0);
      end
      chk("sat_wide_count", 16'(match_count), 16'd5);
      chk("sat_sticks", 16'(match_count_s), 16'd3);

      // Reset mid-pattern discards history
      do_reset(1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0); chk("mid_pre_state", 16'(state_out), 16'd3);
      do_reset(1);
      chk("mid_rst_state", 16'(state_out), 16'd0);
      chk("mid_rst_count", 16'(match_count), 16'd0);
      step(1'b1, 1'b1, 1'b0);
      chk("mid_nodet", 16'(detect), 16'd0);
      chk("mid_state", 16'(state_out), 16'd1);
      step(1'b0, 1'b0, 1'b0);
      chk("mid_nodet_late", 16'(detect), 16'd0);
      chk("mid_count", 16'(match_count), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
